// File: rtl/demux_dispatch_sched.sv
// demux_dispatch_sched: one-register scheduler that steers words to eight valid/ready channels
// The optional wait-counter timeout is enabled by defining DISPATCH_TIMEOUT_EN.
module demux_dispatch_sched #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_dest_vld_i,
    input  logic [2:0]       in_dest_i,
    input  logic [7:0]       ch_en_i,
    output logic [7:0]       out_valid_o,
    input  logic [7:0]       out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [2:0]       sel_o,
    output logic             busy_o,
    output logic [7:0]       drop_cnt_o
);
    logic             busy_q, busy_d;
    logic             rr_word_q, rr_word_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       rr_q, rr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;
    logic [2:0]       rr_dest, dest;
    logic             out_fire, tmo_drop, done, free, avail, in_fire, load, discard;

    assign out_fire = busy_q & out_ready_i[sel_q];

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    assign tmo_drop = busy_q & ~out_ready_i[sel_q] & (wait_q == 8'(TIMEOUT - 1));
    assign wait_d   = load ? 8'd0 : (busy_q & ~out_fire) ? wait_q + 8'd1 : wait_q;

    // Wait counter: age of the held word, restarted by every load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    // Without the wait counter a held word never expires
    assign tmo_drop = busy_q & (TIMEOUT == 0);
`endif

    assign done       = out_fire | tmo_drop;
    assign free       = ~busy_q | done;
    assign avail      = in_dest_vld_i | (|ch_en_i);
    assign in_ready_o = rst_n & free & avail;
    assign in_fire    = in_valid_i & in_ready_o;
    assign rr_d       = (done & rr_word_q) ? sel_q + 3'd1 : rr_q;

    // Round-robin search starts at the pointer as it stands after this cycle's completion
    always_comb begin
        rr_dest = rr_d;
        for (int k = 7; k >= 0; k--)
            if (ch_en_i[rr_d + 3'(k)]) rr_dest = rr_d + 3'(k);
    end

    assign dest      = in_dest_vld_i ? in_dest_i : rr_dest;
    assign load      = in_fire & ch_en_i[dest];
    assign discard   = in_fire & ~ch_en_i[dest];
    assign busy_d    = load | (busy_q & ~done);
    assign sel_d     = load ? dest : sel_q;
    assign data_d    = load ? in_data_i : data_q;
    assign rr_word_d = load ? ~in_dest_vld_i : rr_word_q;
    assign drop_sum  = {1'b0, drop_q} + 9'(discard) + 9'(tmo_drop);
    assign drop_d    = drop_sum > 9'd255 ? 8'd255 : drop_sum[7:0];

    // Output register, round-robin pointer and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            rr_word_q <= 1'b0;
            sel_q     <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            drop_q    <= '0;
        end else begin
            busy_q    <= busy_d;
            rr_word_q <= rr_word_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
        end
    end

    assign out_valid_o = busy_q ? 8'b1 << sel_q : 8'b0;
    assign out_data_o  = data_q;
    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign drop_cnt_o  = drop_q;
endmodule

// File: doc/demux_dispatch_sched.md
# demux_dispatch_sched

Scheduler that sits in front of the 1-to-8 demux datapath and decides which of eight output channels receives each incoming word. Words arrive on a single valid/ready input and are held in one output register. The register drives one of eight valid/ready output channels, chosen by an explicit destination or by a round-robin pointer that skips disabled channels. The block owns the demux select lines and counts discarded words.

## Interface

Parameters:
- `WIDTH`, default 8: data word width in bits.
- `TIMEOUT`, default 16: wait limit in cycles, used only when `DISPATCH_TIMEOUT_EN` is defined. Legal range is 2..255.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an input word is offered.
- `in_ready`, output, 1: the block accepts the offered word this cycle.
- `in_data`, input, `WIDTH`: input word.
- `in_dest_vld`, input, 1: 1 = use `in_dest`; 0 = use the round-robin pointer.
- `in_dest`, input, 3: explicit destination channel.
- `ch_en`, input, 8: per-channel enable mask.
- `out_valid`, output, 8: one-hot; at most one bit is set.
- `out_ready`, input, 8: per-channel accept.
- `out_data`, output, `WIDTH`: held word, common to all channels.
- `sel`, output, 3: demux select; equals the index of the set `out_valid` bit.
- `busy`, output, 1: the output register holds a word.
- `drop_cnt`, output, 8: number of discarded words; saturates at 255.

## Operation

- Two states:
  - EMPTY: `busy`=0.
  - FULL: `busy`=1, and `out_valid[sel]`=1.
- Output fire: FULL and `out_ready[sel]`=1.
- Input fire: `in_valid` and `in_ready`.
- `in_ready` = `rst_n` AND (EMPTY OR output fire) AND destination available.
  - In explicit mode the destination is always available.
  - In round-robin mode the destination is available when at least one `ch_en` bit is set.
  - `in_ready` depends combinationally on `out_ready`, `in_dest_vld` and `ch_en`.
- Destination resolution at input fire:
  - Explicit mode: the destination is `in_dest`.
  - Round-robin mode: the destination is the first enabled channel found searching circularly from `rr_ptr` upward (wrapping 7 to 0).
- Enabled destination: the word is loaded into `out_data`, `sel` is set to the destination, and the state becomes FULL.
- Explicit destination with its `ch_en` bit = 0: the word is accepted and discarded.
  - The register is not loaded.
  - `drop_cnt` increments.
  - If an output fire happens in the same cycle, the state becomes EMPTY.
- Output fire with no simultaneous load: the state becomes EMPTY.
- Output fire with a simultaneous load: the state stays FULL with the new word. This gives back-to-back throughput of 1 word per cycle.
- `rr_ptr` (3 bits) is updated when a round-robin word completes:
  - it completes by output fire or by timeout drop;
  - `rr_ptr` becomes (delivered channel + 1) mod 8.
  - Explicit-mode words never move `rr_ptr`.
- `ch_en` changes while FULL do not affect the held word: it stays on `sel` until it completes.
- `drop_cnt` saturates at 255 and never wraps. A drop while at 255 leaves it at 255.

## Timing

- Reset values (asynchronous on `rst_n` low):
  - `out_valid`=0, `out_data`=0, `sel`=0, `busy`=0, `drop_cnt`=0;
  - `rr_ptr`=0, internal wait counter=0;
  - `in_ready`=0 while `rst_n`=0.
- Reset asserted while FULL discards the held word without counting it.
- Latency: input fire in cycle N puts `out_valid[dest]` high in cycle N+1.
- `out_valid` and `out_data` are stable while FULL and `out_ready[sel]`=0.
- Drop counting when two drops occur in the same cycle (a discard and a timeout drop): `drop_cnt` increases by 2, still saturating.

## Configuration

- Macro: `DISPATCH_TIMEOUT_EN`.
- When defined:
  - A wait counter clears on each load and increments on every FULL cycle without output fire.
  - When the counter reaches `TIMEOUT`-1 and `out_ready[sel]`=0 that cycle, the word is dropped.
  - On that edge `busy` goes to 0 and `out_valid` goes to 0, `drop_cnt` increments, and `rr_ptr` advances as if the word were delivered.
  - During the drop cycle `in_ready` behaves as for an output fire, so a new word may load in that cycle.
- When undefined:
  - No wait counter is built.
  - A FULL word waits indefinitely.
  - `drop_cnt` counts only discards to disabled channels.

## Test plan

- **Round-robin fill.** `ch_en`=FF, `in_dest_vld`=0, all `out_ready`=1, 10 words sent back-to-back → channels 0,1,…,7,0,1 in order, one word per cycle, `rr_ptr`=2 at the end.
- **Skip disabled channels.** `ch_en`=8'b0010_0100, round-robin mode, 4 words → channels 2,5,2,5. With `ch_en`=0 → `in_ready`=0 and the word is held.
- **Explicit destination with backpressure.** `in_dest`=6, `out_ready[6]`=0 for 5 cycles then 1 → `out_valid`=8'h40 and `out_data` stable for 5 cycles; the next word is accepted on the fire cycle; `rr_ptr` is unchanged.
- **Discard to a disabled channel.** `in_dest`=3 with `ch_en[3]`=0 → `in_ready`=1, no `out_valid`, `drop_cnt` 0→1. After 300 such words `drop_cnt`=255.
- **Timeout (macro defined, `TIMEOUT`=4).** Word to channel 1 with `out_ready`=0 → `out_valid[1]` is high for exactly 4 cycles, then `busy`=0, `drop_cnt`=1, `rr_ptr`=2. Without the macro, `out_valid[1]` stays high for 100 cycles.
- **Reset while FULL.** `rst_n` low while `out_valid[4]`=1 → all outputs are 0 immediately, `drop_cnt`=0, and the first round-robin word after release goes to channel 0.
